// File: rtl/psg_mix_pkg.sv
// Shared definitions for the PSG filter/mixer: filter select encoding,
// filter coefficients, sequencer states and width helpers.
package psg_mix_pkg;

  typedef enum logic [1:0] {
    FSEL_BYPASS = 2'b00,
    FSEL_2497   = 2'b01,
    FSEL_533    = 2'b10,
    FSEL_440    = 2'b11
  } fsel_e;

  // One-pole coefficients, Q16 (alpha / 65536) at 48 kHz sample rate
  localparam logic [15:0] ALPHA_2497 = 16'd18279;
  localparam logic [15:0] ALPHA_533  = 16'd4421;
  localparam logic [15:0] ALPHA_440  = 16'd3664;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILT,
    ST_GAIN,
    ST_OUT
  } state_e;

  // Filter state width: channel level scaled up by 32
  function automatic int sw_of(input int iw);
    return iw + 5;
  endfunction

  // Mix accumulator width: headroom for NCH filter outputs plus one spare bit
  function automatic int acc_w(input int iw, input int nch);
    return iw + 5 + $clog2(nch) + 1;
  endfunction

  function automatic logic [15:0] alpha_of(input logic [1:0] fsel);
    case (fsel)
      FSEL_2497: return ALPHA_2497;
      FSEL_533:  return ALPHA_533;
      FSEL_440:  return ALPHA_440;
      default:   return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/psg_lpf_alu.sv
// Single-channel one-pole low-pass step: M_new = M + floor((I - M) * alpha / 65536),
// or M_new = I when bypassed. Purely combinational, shared across channels.
module psg_lpf_alu
  import psg_mix_pkg::*;
#(
  parameter int IW = 8,
  parameter int SW = sw_of(IW)
) (
  input  logic [IW-1:0] lvl,
  input  logic [SW-1:0] m,
  input  logic [1:0]    fsel,
  output logic [SW-1:0] m_new
);

  localparam int PW = SW + 17;

  logic [SW-1:0]        i_val;
  logic signed [SW:0]   diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] alpha_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;
  logic signed [PW-1:0] sum_x;

  // Signed difference, signed product, arithmetic shift gives floor rounding
  always_comb begin
    i_val   = {lvl, 5'b0};
    diff    = $signed({1'b0, i_val}) - $signed({1'b0, m});
    diff_x  = PW'(diff);
    alpha_x = $signed({{(PW-16){1'b0}}, alpha_of(fsel)});
    prod    = diff_x * alpha_x;
    step    = prod >>> 16;
    sum_x   = PW'($signed({1'b0, m})) + step;
    m_new   = (fsel == FSEL_BYPASS) ? i_val : SW'(sum_x);
  end

endmodule

// File: rtl/psg_filter_mixer.sv
// Time-multiplexed PSG mixer: per-channel low-pass filter, mute and L/R
// routing through one shared filter ALU, master gain and saturated output.
module psg_filter_mixer
  import psg_mix_pkg::*;
#(
  parameter int NCH     = 6,
  parameter int IW      = 8,
  parameter int OW      = 16,
  parameter int SMP_DIV = 1024
) (
  input  logic                MCLK,
  input  logic                RESET_N,
  input  logic [NCH*IW-1:0]   CH_IN,
  input  logic [2*NCH-1:0]    FSEL,
  input  logic [2*NCH-1:0]    PAN,
  input  logic [NCH-1:0]      MUTE,
  input  logic [8:0]          GAIN,
  output logic [OW-1:0]       OUT_L,
  output logic [OW-1:0]       OUT_R,
  output logic                SMPCL
);

  localparam int SW  = sw_of(IW);
  localparam int AW  = acc_w(IW, NCH);
  localparam int PRW = AW + 9;
  localparam int CW  = $clog2(SMP_DIV);
  localparam int XW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [XW-1:0] LAST    = XW'(NCH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SMP_DIV - 1);

  state_e state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [XW-1:0]     idx;
  logic [NCH*IW-1:0] ch_s;
  logic [2*NCH-1:0]  fsel_s;
  logic [2*NCH-1:0]  pan_s;
  logic [NCH-1:0]    mute_s;
  logic [8:0]        gain_s;
  logic [SW-1:0]     m_mem [NCH];
  logic [AW-1:0]     acc_l, acc_r;
  logic [PRW-1:0]    p_l, p_r;
  logic [PRW-1:0]    mul_l, mul_r;

  logic [IW-1:0] lvl_cur;
  logic [1:0]    fsel_cur;
  logic [1:0]    pan_cur;
  logic          mute_cur;
  logic [SW-1:0] m_cur;
  logic [SW-1:0] m_new;

  psg_lpf_alu #(.IW(IW)) u_alu (
    .lvl   (lvl_cur),
    .m     (m_cur),
    .fsel  (fsel_cur),
    .m_new (m_new)
  );

  // Select the snapshot fields and filter state of the channel being processed
  always_comb begin
    lvl_cur  = '0;
    fsel_cur = '0;
    pan_cur  = '0;
    mute_cur = 1'b0;
    m_cur    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx == XW'(c)) begin
        lvl_cur  = ch_s[c*IW +: IW];
        fsel_cur = fsel_s[2*c +: 2];
        pan_cur  = pan_s[2*c +: 2];
        mute_cur = mute_s[c];
        m_cur    = m_mem[c];
      end
    end
  end

  // Full-width master gain products
  always_comb begin
    mul_l = PRW'(acc_l) * PRW'(gain_s);
    mul_r = PRW'(acc_r) * PRW'(gain_s);
  end

  // Free-running sample period counter
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)            cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  // Sequencer state register
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Sequencer next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cnt == '0) state_nxt = ST_FILT;
      ST_FILT: if (idx == LAST) state_nxt = ST_GAIN;
      ST_GAIN: state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: snapshot, filter/accumulate, gain, saturate and strobe
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx    <= '0;
      ch_s   <= '0;
      fsel_s <= '0;
      pan_s  <= '0;
      mute_s <= '0;
      gain_s <= '0;
      acc_l  <= '0;
      acc_r  <= '0;
      p_l    <= '0;
      p_r    <= '0;
      OUT_L  <= '0;
      OUT_R  <= '0;
      SMPCL  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) m_mem[c] <= '0;
    end else begin
      SMPCL <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cnt == '0) begin
            ch_s   <= CH_IN;
            fsel_s <= FSEL;
            pan_s  <= PAN;
            mute_s <= MUTE;
            gain_s <= GAIN;
            idx    <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
          end
        end
        ST_FILT: begin
          for (int unsigned c = 0; c < NCH; c++) begin
            if (idx == XW'(c)) m_mem[c] <= m_new;
          end
          if (!mute_cur) begin
            if (pan_cur[0]) acc_l <= acc_l + AW'(m_new);
            if (pan_cur[1]) acc_r <= acc_r + AW'(m_new);
          end
          idx <= idx + 1'b1;
        end
        ST_GAIN: begin
          p_l <= mul_l >> 8;
          p_r <= mul_r >> 8;
        end
        ST_OUT: begin
          OUT_L <= (|p_l[PRW-1:OW]) ? '1 : p_l[OW-1:0];
          OUT_R <= (|p_r[PRW-1:OW]) ? '1 : p_r[OW-1:0];
          SMPCL <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_filter_mixer.sv
// Directed and randomised checks of psg_filter_mixer against an arithmetic
// reference model of the per-sample mix.
module tb_psg_filter_mixer;

  localparam int NCH     = 6;
  localparam int IW      = 8;
  localparam int OW      = 16;
  localparam int SMP_DIV = 256;

  logic              MCLK = 1'b0;
  logic              RESET_N;
  logic [NCH*IW-1:0] CH_IN;
  logic [2*NCH-1:0]  FSEL;
  logic [2*NCH-1:0]  PAN;
  logic [NCH-1:0]    MUTE;
  logic [8:0]        GAIN;
  logic [OW-1:0]     OUT_L, OUT_R;
  logic              SMPCL;

  psg_filter_mixer #(
    .NCH     (NCH),
    .IW      (IW),
    .OW      (OW),
    .SMP_DIV (SMP_DIV)
  ) dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .CH_IN   (CH_IN),
    .FSEL    (FSEL),
    .PAN     (PAN),
    .MUTE    (MUTE),
    .GAIN    (GAIN),
    .OUT_L   (OUT_L),
    .OUT_R   (OUT_R),
    .SMPCL   (SMPCL)
  );

  always #5 MCLK = ~MCLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int ch_v [NCH];
  int fs_v [NCH];
  int pn_v [NCH];
  bit mu_v [NCH];
  int gain_v;

  longint mm [NCH];
  int alpha_tab [4] = '{0, 18279, 4421, 3664};

  int hold_err = 0;
  logic [OW-1:0] prev_l = '0, prev_r = '0;

  // Outputs may only move on the edge that raises SMPCL
  always @(negedge MCLK) begin
    if (RESET_N === 1'b1 && SMPCL !== 1'b1) begin
      if (OUT_L !== prev_l || OUT_R !== prev_r) hold_err++;
    end
    prev_l = OUT_L;
    prev_r = OUT_R;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int c = 0; c < NCH; c++) begin
      CH_IN[c*IW +: IW] = IW'(ch_v[c]);
      FSEL[2*c +: 2]    = 2'(fs_v[c]);
      PAN[2*c +: 2]     = 2'(pn_v[c]);
      MUTE[c]           = mu_v[c];
    end
    GAIN = 9'(gain_v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mm[c] = 0;
  endtask

  // One output sample from the current inputs, updating the model filter states
  task automatic model_sample(output int el, output int er);
    longint al, ar, target, num, q;
    al = 0;
    ar = 0;
    for (int c = 0; c < NCH; c++) begin
      target = longint'(ch_v[c]) * 32;
      if (fs_v[c] == 0) mm[c] = target;
      else begin
        num = (target - mm[c]) * alpha_tab[fs_v[c]];
        q = num / 65536;
        if (q * 65536 > num) q = q - 1;
        mm[c] = mm[c] + q;
      end
      if (!mu_v[c]) begin
        if ((pn_v[c] & 1) != 0) al += mm[c];
        if ((pn_v[c] & 2) != 0) ar += mm[c];
      end
    end
    al = (al * gain_v) / 256;
    ar = (ar * gain_v) / 256;
    el = (al > 65535) ? 65535 : int'(al);
    er = (ar > 65535) ? 65535 : int'(ar);
  endtask

  // Wait for the next strobe, compare against the model, then check strobe width
  task automatic do_sample(input string tag, output int lat, output int ol, output int orr);
    int el, er;
    model_sample(el, er);
    lat = 0;
    do begin
      @(negedge MCLK);
      lat++;
    end while (SMPCL !== 1'b1 && lat < SMP_DIV + NCH + 8);
    check({tag, "_smpcl_seen"}, 32'(SMPCL), 1);
    ol  = int'(OUT_L);
    orr = int'(OUT_R);
    check({tag, "_l"}, 32'(OUT_L), el);
    check({tag, "_r"}, 32'(OUT_R), er);
    @(negedge MCLK);
    check({tag, "_smpcl_width"}, 32'(SMPCL), 0);
  endtask

  initial begin
    int lat, ol, orr, prev;

    RESET_N = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ch_v[c] = 0; fs_v[c] = 0; pn_v[c] = 0; mu_v[c] = 1'b1;
    end
    gain_v = 256;
    apply();
    model_reset();
    repeat (3) @(negedge MCLK);
    check("rst_out_l", 32'(OUT_L), 0);
    check("rst_out_r", 32'(OUT_R), 0);
    check("rst_smpcl", 32'(SMPCL), 0);

    // Bypass DC on channel 0 to left only
    ch_v[0] = 8'hFF; fs_v[0] = 0; pn_v[0] = 1; mu_v[0] = 1'b0;
    apply();
    RESET_N = 1'b1;
    do_sample("bypass", lat, ol, orr);
    check("first_latency", lat, NCH + 3);
    check("bypass_dc_l", ol, 32'h1FE0);
    check("bypass_dc_r", orr, 0);

    // Saturation: everything full scale, both sides, max gain
    for (int c = 0; c < NCH; c++) begin
      ch_v[c] = 8'hFF; fs_v[c] = 0; pn_v[c] = 3; mu_v[c] = 1'b0;
    end
    gain_v = 511;
    apply();
    do_sample("sat", lat, ol, orr);
    check("sat_period", lat + 1, SMP_DIV);
    check("sat_l", ol, 32'hFFFF);
    check("sat_r", orr, 32'hFFFF);

    // Filter rising step on channel 0 from a cleared state
    for (int c = 1; c < NCH; c++) mu_v[c] = 1'b1;
    ch_v[0] = 0; fs_v[0] = 0; pn_v[0] = 1; gain_v = 256;
    apply();
    do_sample("step_clear", lat, ol, orr);
    ch_v[0] = 8'hFF; fs_v[0] = 1;
    apply();
    prev = 0;
    for (int k = 0; k < 40; k++) begin
      do_sample("step", lat, ol, orr);
      if (k == 0) check("step_first", ol, 2275);
      else if (prev < 8157) check("step_rise", 32'(ol > prev), 1);
      else check("step_hold", ol, prev);
      prev = ol;
    end
    check("step_settle", 32'(ol >= 8157 && ol <= 8160), 1);
    check("step_period", lat + 1, SMP_DIV);

    // Falling step settles exactly to zero
    ch_v[0] = 0;
    apply();
    for (int k = 0; k < 36; k++) do_sample("fall", lat, ol, orr);
    check("fall_zero", ol, 0);

    // Muted channel keeps filtering; unmute continues from tracked state
    fs_v[0] = 2; mu_v[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      ch_v[0] = 40 * k;
      apply();
      do_sample("mute", lat, ol, orr);
      check("mute_zero_l", ol, 0);
    end
    mu_v[0] = 1'b0;
    apply();
    do_sample("unmute", lat, ol, orr);
    check("unmute_no_restart", 32'(ol > 518), 1);

    // Randomised mixes
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < NCH; c++) begin
        ch_v[c] = int'($urandom_range(0, 255));
        fs_v[c] = int'($urandom_range(0, 3));
        pn_v[c] = int'($urandom_range(0, 3));
        mu_v[c] = bit'($urandom_range(0, 1));
      end
      gain_v = int'($urandom_range(0, 511));
      apply();
      do_sample("rand", lat, ol, orr);
    end

    check("out_hold", hold_err, 0);

    // Reset in the middle of the filter pass (cnt == 3)
    repeat (SMP_DIV - NCH - 1) @(negedge MCLK);
    #1 RESET_N = 1'b0;
    #1;
    check("midrst_out_l", 32'(OUT_L), 0);
    check("midrst_out_r", 32'(OUT_R), 0);
    check("midrst_smpcl", 32'(SMPCL), 0);
    model_reset();
    repeat (4) @(negedge MCLK);
    check("midrst_hold_smpcl", 32'(SMPCL), 0);
    RESET_N = 1'b1;
    do_sample("restart", lat, ol, orr);
    check("restart_latency", lat, NCH + 3);
    do_sample("restart2", lat, ol, orr);
    check("restart_period", lat + 1, SMP_DIV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
